// File: rtl/pc_sequencer.sv
// MIPS fetch-stage controller: owns the PC, fetches over req/ack, buffers one
// instruction for decode and applies jump/branch/jr redirects.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_type,
    input  logic [31:0] redirect_pc4,
    input  logic [25:0] jump_index,
    input  logic [15:0] branch_offset,
    input  logic [31:0] jr_target,
    input  logic        halt
);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        pending_q, pending_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        outstanding_q, outstanding_d;

    logic        req;
    logic        redir;
    logic        waiting;
    logic [31:0] target;

    always_comb begin
        case (redirect_type)
            2'b01:   target = {redirect_pc4[31:28], jump_index, 2'b00};
            2'b10:   target = redirect_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
            default: target = jr_target & 32'hFFFF_FFFC;
        endcase
    end

    assign req     = (state_q == FETCH) && (outstanding_q || !instr_valid_q || !stall);
    assign waiting = req && !imem_ack;
    assign redir   = redirect_valid && (redirect_type != 2'b00) && (state_q != HALT);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pending_d     = pending_q;
        pend_target_d = pend_target_q;
        outstanding_d = waiting;

        case (state_q)
            IDLE:    state_d = halt ? HALT : FETCH;
            FETCH:   if (halt && !waiting) state_d = HALT;
            default: state_d = HALT;
        endcase

        // A redirect during an unanswered request is parked so the address
        // stays stable until the ack; the word that comes back is dropped.
        if (redir) begin
            instr_valid_d = 1'b0;
            if (waiting) begin
                pending_d     = 1'b1;
                pend_target_d = target;
            end else begin
                pc_d      = target;
                pending_d = 1'b0;
            end
        end else if (req && imem_ack) begin
            if (pending_q) begin
                pc_d      = pend_target_q;
                pending_d = 1'b0;
                if (instr_valid_q && !stall) instr_valid_d = 1'b0;
            end else begin
                instr_d       = imem_rdata;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                pc_d          = pc_q + 32'd4;
            end
        end else if (instr_valid_q && !stall) begin
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            pending_q     <= 1'b0;
            pend_target_q <= '0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            pending_q     <= pending_d;
            pend_target_q <= pend_target_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed plan steps followed by a
// randomized phase, all checked against a cycle-level behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        stall;
    logic        redirect_valid;
    logic [1:0]  redirect_type;
    logic [31:0] redirect_pc4;
    logic [25:0] jump_index;
    logic [15:0] branch_offset;
    logic [31:0] jr_target;
    logic        halt;

    logic        ack_tie;
    logic        ack_r;
    int unsigned lat;
    int unsigned req_cnt;

    int tests = 0;
    int fails = 0;

    // model state: mode 0 idle, 1 fetching, 2 halted
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_ipc, m_ptgt;
    logic        m_have, m_pend, m_waiting, m_req, m_ack;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = ack_tie ? imem_req : ack_r;

    pc_sequencer #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_type(redirect_type), .redirect_pc4(redirect_pc4),
        .jump_index(jump_index), .branch_offset(branch_offset), .jr_target(jr_target), .halt(halt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_target(input logic [1:0] t, input logic [31:0] pc4,
                                               input logic [25:0] idx, input logic [15:0] off,
                                               input logic [31:0] jr);
        logic signed [31:0] soff;
        soff = 32'($signed(off));
        case (t)
            2'd1:    return (pc4 & 32'hF000_0000) | (32'(idx) * 4);
            2'd2:    return pc4 + 32'(soff * 4);
            default: return jr - (jr % 4);
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = RPC; m_instr = '0; m_ipc = '0; m_ptgt = '0;
        m_have = 0; m_pend = 0; m_waiting = 0; req_cnt = 0;
    endtask

    task automatic model_step();
        logic        take;
        logic        drain;
        logic [31:0] tgt;
        int          nmode;
        take  = redirect_valid && redirect_type != 2'd0 && m_mode != 2;
        drain = m_have && !stall;
        tgt   = ref_target(redirect_type, redirect_pc4, jump_index, branch_offset, jr_target);
        nmode = m_mode;
        if (m_mode == 0) nmode = halt ? 2 : 1;
        else if (m_mode == 1 && halt && !(m_req && !m_ack)) nmode = 2;
        if (take) begin
            m_have = 0;
            if (m_req && !m_ack) begin m_pend = 1; m_ptgt = tgt; end
            else begin m_pc = tgt; m_pend = 0; end
        end else if (m_req && m_ack) begin
            if (m_pend) begin
                m_pc = m_ptgt; m_pend = 0;
                if (drain) m_have = 0;
            end else begin
                m_instr = mem_word(m_pc); m_ipc = m_pc; m_have = 1; m_pc = m_pc + 4;
            end
        end else if (drain) begin
            m_have = 0;
        end
        m_waiting = m_req && !m_ack;
        req_cnt   = (m_req && !m_ack) ? req_cnt + 1 : 0;
        m_mode    = nmode;
    endtask

    task automatic check_outputs();
        chk("imem_req", 32'(imem_req), 32'(m_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_have));
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
    endtask

    task automatic cycle();
        m_req = (m_mode == 1) && (m_waiting || !m_have || !stall);
        ack_r = m_req && (req_cnt >= lat);
        m_ack = ack_tie ? m_req : ack_r;
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic redirect(input logic [1:0] t, input logic [31:0] pc4, input logic [25:0] idx,
                            input logic [15:0] off, input logic [31:0] jr);
        redirect_valid = 1'b1; redirect_type = t; redirect_pc4 = pc4;
        jump_index = idx; branch_offset = off; jr_target = jr;
    endtask

    logic [31:0] x, si, sp;

    initial begin
        rst = 1'b1; stall = 1'b0; halt = 1'b0; ack_tie = 1'b1; ack_r = 1'b0; lat = 0;
        redirect_valid = 1'b0; redirect_type = '0; redirect_pc4 = '0;
        jump_index = '0; branch_offset = '0; jr_target = '0;
        model_reset();
        m_req = 0; m_ack = 0;
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // reset release and zero-wait streaming
        cycle();
        #1; chk("first_addr", imem_addr, 32'h0040_0000); chk("first_req", 32'(imem_req), 32'd1);
        cycle();
        #1; chk("addr_4", imem_addr, 32'h0040_0004); chk("valid_3rd", 32'(instr_valid), 32'd1);
        chk("ipc_lag", instr_pc, 32'h0040_0000);
        cycle();
        #1; chk("addr_8", imem_addr, 32'h0040_0008);

        redirect(2'd1, 32'h9000_0010, 26'h0000_100, '0, '0);
        cycle();
        #1; chk("jump_addr", imem_addr, 32'h9000_0400); chk("jump_flush", 32'(instr_valid), 32'd0);
        cycle();
        redirect(2'd2, 32'h0000_0100, '0, 16'hFFFE, '0);
        cycle();
        #1; chk("branch_back", imem_addr, 32'h0000_00F8);
        redirect(2'd2, 32'h0000_0100, '0, 16'h0004, '0);
        cycle();
        #1; chk("branch_fwd", imem_addr, 32'h0000_0110);
        cycle();

        // slow memory with jr one cycle into the wait
        ack_tie = 1'b0; lat = 3; x = m_pc;
        cycle();
        redirect(2'd3, '0, '0, '0, 32'h0000_2003);
        cycle();
        #1; chk("jr_hold1", imem_addr, x);
        cycle();
        #1; chk("jr_hold2", imem_addr, x);
        cycle();
        #1; chk("jr_addr", imem_addr, 32'h0000_2000); chk("jr_discard", 32'(instr_valid), 32'd0);

        // stall with a buffered instruction
        ack_tie = 1'b1; lat = 0;
        repeat (2) cycle();
        si = instr; sp = instr_pc; stall = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            cycle();
            #1; chk("stall_instr", instr, si); chk("stall_ipc", instr_pc, sp);
            chk("stall_noreq", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        cycle();
        #1; chk("resume_ipc", instr_pc, sp + 32'd4); chk("resume_valid", 32'(instr_valid), 32'd1);

        // pc wrap
        redirect(2'd3, '0, '0, '0, 32'hFFFF_FFFC);
        cycle();
        #1; chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
        cycle();
        #1; chk("wrap_zero", imem_addr, 32'h0000_0000); chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);

        // halt: no requests, redirects ignored, buffer drains
        halt = 1'b1;
        cycle();
        #1; chk("halt_noreq", 32'(imem_req), 32'd0); chk("halt_last", 32'(instr_valid), 32'd1);
        redirect(2'd1, 32'h9000_0010, 26'h0000_100, '0, '0);
        cycle();
        #1; chk("halt_pc", imem_addr, 32'h0000_0004); chk("halt_drain", 32'(instr_valid), 32'd0);
        repeat (3) cycle();

        // reset asserted in the middle of a slow fetch
        rst = 1'b1; #1; model_reset();
        @(negedge clk);
        halt = 1'b0; rst = 1'b0; ack_tie = 1'b0; lat = 3;
        repeat (3) cycle();
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0); chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", 32'(instr_valid), 32'd0); chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic
        for (int unsigned n = 0; n < 800; n++) begin
            if (req_cnt == 0 && $urandom_range(0, 15) == 0) begin
                ack_tie = 1'($urandom_range(0, 1));
                lat = $urandom_range(0, 3);
            end
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0)
                redirect(2'($urandom_range(0, 3)), $urandom, 26'($urandom), 16'($urandom), $urandom);
            cycle();
        end
        halt = 1'b1;
        repeat (8) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
